// File: rtl/fft_pkg.sv
// Shared definitions for the R2SDF IFFT stages: widths, FSM encoding, shift/saturate helpers.
// IFFT_SDF_ROUND_EN selects round-half-up shifts instead of arithmetic truncation.
package fft_pkg;

    localparam int unsigned SAMPLE_W = 14;
    localparam int unsigned TW_W     = 14;
    localparam int unsigned ACC_W    = 64;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        StPrime = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    function automatic acc_t rshift(input acc_t v, input int unsigned sh);
`ifdef IFFT_SDF_ROUND_EN
        acc_t one;
        one = acc_t'(1);
        return (v + (one <<< (sh - 1))) >>> sh;
`else
        return v >>> sh;
`endif
    endfunction

    function automatic acc_t sat(input acc_t v, input int unsigned w);
        acc_t mx;
        acc_t mn;
        mx = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        mn = -mx - acc_t'(1);
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

endpackage

// File: rtl/cmul_conj_pipe.sv
// Registered multiply by conj(W) with scaling, saturation and an exact x1 bypass.
// Output data holds its value between enabled cycles.
module cmul_conj_pipe
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH    = SAMPLE_W,
    parameter int unsigned TW_WIDTH = TW_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       bypass,
    input  logic signed [WIDTH-1:0]    d_re,
    input  logic signed [WIDTH-1:0]    d_im,
    input  logic signed [TW_WIDTH-1:0] tw_re,
    input  logic signed [TW_WIDTH-1:0] tw_im,
    output logic                       out_valid,
    output logic signed [WIDTH-1:0]    out_re,
    output logic signed [WIDTH-1:0]    out_im
);

    acc_t                    prod_re;
    acc_t                    prod_im;
    logic signed [WIDTH-1:0] res_re_d;
    logic signed [WIDTH-1:0] res_im_d;
    logic                    valid_q;
    logic signed [WIDTH-1:0] re_q;
    logic signed [WIDTH-1:0] im_q;

    // conj(W) = tw_re - j*tw_im
    always_comb begin
        prod_re  = acc_t'(d_re) * acc_t'(tw_re) + acc_t'(d_im) * acc_t'(tw_im);
        prod_im  = acc_t'(d_im) * acc_t'(tw_re) - acc_t'(d_re) * acc_t'(tw_im);
        res_re_d = WIDTH'(sat(rshift(prod_re, TW_WIDTH - 1), WIDTH));
        res_im_d = WIDTH'(sat(rshift(prod_im, TW_WIDTH - 1), WIDTH));
        if (bypass) begin
            res_re_d = d_re;
            res_im_d = d_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            valid_q <= en;
            if (en) begin
                re_q <= res_re_d;
                im_q <= res_im_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_re    = re_q;
    assign out_im    = im_q;

endmodule

// File: rtl/ifft_r2sdf_stage.sv
// One radix-2 single-delay-feedback DIF stage of the inverse FFT (multiplies by conj(W)).
// Rounding of all shifts is selected by IFFT_SDF_ROUND_EN (see fft_pkg).
module ifft_r2sdf_stage
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH     = SAMPLE_W,
    parameter int unsigned DELAY     = 4,
    parameter int unsigned TW_STRIDE = 1,
    parameter int unsigned TW_AW     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    drain,
    output logic [TW_AW-1:0]        tw_addr,
    input  logic signed [WIDTH-1:0] tw_re,
    input  logic signed [WIDTH-1:0] tw_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im
);

    localparam int unsigned CW = $clog2(2 * DELAY);
    localparam int unsigned AW = (DELAY > 1) ? $clog2(DELAY) : 1;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW_AW-1:0]        tw_addr_q;
    logic signed [WIDTH-1:0] mem_re [DELAY];
    logic signed [WIDTH-1:0] mem_im [DELAY];

    logic                    phase_b, drain_go, draining, step, last_drain;
    logic [AW-1:0]           ptr;
    logic signed [WIDTH-1:0] x_re, x_im, head_re, head_im;
    logic signed [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;

    logic                    s1_valid_q, s1_bypass_q, s2_valid_q, s2_bypass_q;
    logic signed [WIDTH-1:0] s1_re_q, s1_im_q, s2_re_q, s2_im_q;

    function automatic logic signed [WIDTH-1:0] half(input acc_t v);
        return WIDTH'(sat(rshift(v, 1), WIDTH));
    endfunction

    always_comb begin
        phase_b    = cnt_q >= CW'(DELAY);
        drain_go   = drain && (state_q == StRun) && (cnt_q == '0);
        draining   = drain_go || (state_q == StDrain);
        in_ready   = !draining;
        step       = draining || in_valid;
        last_drain = draining && (cnt_q == CW'(DELAY - 1));
        ptr        = AW'(cnt_q % CW'(DELAY));
        x_re       = draining ? '0 : in_re;
        x_im       = draining ? '0 : in_im;
        head_re    = mem_re[ptr];
        head_im    = mem_im[ptr];
        sum_re     = half(acc_t'(head_re) + acc_t'(x_re));
        sum_im     = half(acc_t'(head_im) + acc_t'(x_im));
        dif_re     = half(acc_t'(head_re) - acc_t'(x_re));
        dif_im     = half(acc_t'(head_im) - acc_t'(x_im));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (step) begin
            // a drain always ends on a block boundary, so cnt restarts at 0
            if (last_drain || (cnt_q == CW'(2 * DELAY - 1))) cnt_d = '0;
            else cnt_d = cnt_q + CW'(1);
            case (state_q)
                StPrime: if (phase_b) state_d = StRun;
                StRun:   if (drain_go) state_d = last_drain ? StPrime : StDrain;
                StDrain: if (last_drain) state_d = StPrime;
                default: state_d = StPrime;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StPrime;
            cnt_q       <= '0;
            tw_addr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_bypass_q <= 1'b0;
            s2_re_q     <= '0;
            s2_im_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            // phase-A steps of the first block have no pending difference to emit
            s1_valid_q <= step && !((state_q == StPrime) && !phase_b);
            if (step) begin
                s1_bypass_q <= phase_b || (cnt_q == '0);
                s1_re_q     <= phase_b ? sum_re : head_re;
                s1_im_q     <= phase_b ? sum_im : head_im;
                if (!phase_b) tw_addr_q <= TW_AW'(cnt_q * TW_STRIDE);
            end
            s2_valid_q  <= s1_valid_q;
            s2_bypass_q <= s1_bypass_q;
            s2_re_q     <= s1_re_q;
            s2_im_q     <= s1_im_q;
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            mem_re[ptr] <= phase_b ? dif_re : x_re;
            mem_im[ptr] <= phase_b ? dif_im : x_im;
        end
    end

    assign tw_addr = tw_addr_q;

    // sums ride the multiplier bypass so both paths share one output register
    cmul_conj_pipe #(
        .WIDTH    (WIDTH),
        .TW_WIDTH (WIDTH)
    ) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .en        (s2_valid_q),
        .bypass    (s2_bypass_q),
        .d_re      (s2_re_q),
        .d_im      (s2_im_q),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im)
    );

endmodule

// File: tb/tb_ifft_r2sdf_stage.sv
// Directed bench for ifft_r2sdf_stage (WIDTH=14, DELAY=4) with a W8 forward-twiddle ROM model.
module tb_ifft_r2sdf_stage;
    import fft_pkg::*;

    logic              clk = 1'b0;
    logic              rst, in_valid, drain, in_ready, out_valid;
    logic signed [13:0] in_re, in_im, tw_re, tw_im, out_re, out_im;
    logic [7:0]        tw_addr;

    always #5 clk = ~clk;

    ifft_r2sdf_stage #(
        .WIDTH     (14),
        .DELAY     (4),
        .TW_STRIDE (1),
        .TW_AW     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .drain     (drain),
        .tw_addr   (tw_addr),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    // forward twiddles W8^k, 1-cycle read latency
    always @(posedge clk) begin
        case (tw_addr)
            8'd0:    begin tw_re <= 14'sd8191;  tw_im <= 14'sd0;     end
            8'd1:    begin tw_re <= 14'sd5793;  tw_im <= -14'sd5793; end
            8'd2:    begin tw_re <= 14'sd0;     tw_im <= -14'sd8191; end
            8'd3:    begin tw_re <= -14'sd5793; tw_im <= -14'sd5793; end
            default: begin tw_re <= 14'sd0;     tw_im <= 14'sd0;     end
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int obs_re[$], obs_im[$], obs_cyc[$], exp_cyc[$];
    always @(negedge clk) begin
        if (out_valid) begin
            obs_re.push_back(int'(out_re));
            obs_im.push_back(int'(out_im));
            obs_cyc.push_back(cyc);
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0][13:0] xr;
        logic [7:0][13:0] xi;
        logic [7:0][13:0] er;
        logic [7:0][13:0] ei;
    } vec_t;
    vec_t vecs[4];

    task automatic set_x(input int v, input int i, input int re, input int im);
        vecs[v].xr[i] = 14'(re);
        vecs[v].xi[i] = 14'(im);
    endtask

    task automatic set_e(input int v, input int j, input int re, input int im);
        vecs[v].er[j] = 14'(re);
        vecs[v].ei[j] = 14'(im);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int v, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            in_valid = 1'b1;
            in_re    = $signed(vecs[v].xr[i]);
            in_im    = $signed(vecs[v].xi[i]);
            if (i >= 4) exp_cyc.push_back(cyc + 1);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic do_drain(input bit with_sample, output int lows);
        drain    = 1'b1;
        in_valid = with_sample;
        in_re    = 14'sd7777;
        in_im    = 14'sd0;
        #1;
        lows = in_ready ? 0 : 1;
        for (int k = 0; k < 4; k++) exp_cyc.push_back(cyc + 1 + k);
        @(posedge clk);
        #1;
        drain    = 1'b0;
        in_valid = 1'b0;
        for (int i = 1; i < 6; i++) begin
            if (!in_ready) lows++;
            tick();
        end
    endtask

    task automatic check_vec(input int v, input string tag);
        repeat (3) tick();
        chk($sformatf("%s.count", tag), obs_re.size(), 8);
        for (int j = 0; j < 8; j++) begin
            if (j < obs_re.size()) begin
                chk($sformatf("%s.re[%0d]", tag, j), obs_re[j], int'($signed(vecs[v].er[j])));
                chk($sformatf("%s.im[%0d]", tag, j), obs_im[j], int'($signed(vecs[v].ei[j])));
                chk($sformatf("%s.lat[%0d]", tag, j), obs_cyc[j] - exp_cyc[j], 2);
            end
        end
        obs_re.delete();
        obs_im.delete();
        obs_cyc.delete();
        exp_cyc.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lows;
        for (int v = 0; v < 4; v++) vecs[v] = '0;
        // constant 1000
        for (int i = 0; i < 8; i++) set_x(0, i, 1000, 0);
        for (int j = 0; j < 4; j++) set_e(0, j, 1000, 0);
        // single tone at x[1]
        set_x(1, 1, 4096, 0);
        set_e(1, 1, 2048, 0);
        set_e(1, 5, 1448, 1448);
        // full scale through the k=0 bypass
        set_x(2, 0, 8191, 0);
        set_x(2, 4, -8192, 0);
        set_e(2, 4, 8191, 0);
        // odd LSBs and the k=2, k=3 twiddles
        set_x(3, 0, 3, -3);
        set_x(3, 2, 1000, 2000);
        set_x(3, 3, 3000, 0);
        set_x(3, 6, -1000, 0);
        set_x(3, 7, 1000, 0);
        set_e(3, 2, 0, 1000);
        set_e(3, 3, 2000, 0);
`ifdef IFFT_SDF_ROUND_EN
        set_e(2, 0, 0, 0);
        set_e(3, 0, 2, -1);
        set_e(3, 4, 2, -1);
        set_e(3, 6, -1000, 1000);
        set_e(3, 7, -707, 707);
`else
        set_e(2, 0, -1, 0);
        set_e(3, 0, 1, -2);
        set_e(3, 4, 1, -2);
        set_e(3, 6, -1000, 999);
        set_e(3, 7, -708, 707);
`endif

        rst      = 1'b1;
        in_valid = 1'b0;
        drain    = 1'b0;
        in_re    = '0;
        in_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out_re", int'(out_re), 0);
        chk("rst.out_im", int'(out_im), 0);
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.tw_addr", int'(tw_addr), 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            send_block(v, 1'b0);
            do_drain(1'b0, lows);
            check_vec(v, $sformatf("vec%0d", v));
        end

        send_block(0, 1'b1);
        do_drain(1'b0, lows);
        check_vec(0, "stall");

        // leave a partial block in flight, then reset
        send_block(2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_re    = 14'sd5000;
            in_im    = -14'sd300;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        obs_re.delete();
        obs_im.delete();
        obs_cyc.delete();
        exp_cyc.delete();
        send_block(1, 1'b0);
        do_drain(1'b0, lows);
        check_vec(1, "rst_mid");

        send_block(1, 1'b0);
        do_drain(1'b1, lows);
        chk("collide.ready_low_cycles", lows, 4);
        chk("collide.state_prime", int'(dut.state_q == StPrime), 1);
        check_vec(1, "collide");

        send_block(0, 1'b0);
        do_drain(1'b0, lows);
        check_vec(0, "after_collide");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
